dut_host: RTL and testbench

Host-side sequencer for the cipher core's `init`/`req`/`ack` start–done handshake, i.e. the hardware equivalent of the bench driver. On `start` it runs the full sequence: resets the core, streams a message into the core's data memory, issues a one-cycle `req`, waits for `ack`, then streams the result bytes back out. It sits between a byte-stream source/sink and the core top level, so an encrypt/decrypt pass can run without a testbench.

---
 rtl/dut_host.sv | 188 ++++++++++++++++++
 tb/tb_dut_host.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_host.sv
// Host sequencer for the cipher core: reset core, load message, pulse req, wait for ack, stream results out.
// Source and sink stall on valid/ready; one byte per 2 cycles readback; define DUT_HOST_TIMEOUT_EN for a WAIT watchdog.
module dut_host #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 64,
    parameter int TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       dut_init,
    output logic       dut_req,
    input  logic       dut_ack,
    output logic       mem_wen,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       res_valid,
    output logic [7:0] res_data,
    input  logic       res_ready,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_LOAD, S_REQ, S_WAIT, S_RD_ADDR, S_RD_DATA, S_FIN, S_ERR
    } state_t;

    localparam logic [8:0] LOAD_LAST = 9'(LOAD_LEN - 1);
    localparam logic [8:0] RES_LAST  = 9'(RES_LEN - 1);
    localparam logic [7:0] LOAD_OFS  = 8'(LOAD_BASE);
    localparam logic [7:0] RES_OFS   = 8'(RES_BASE);

    state_t     state;
    state_t     state_nxt;
    logic [8:0] idx;
    logic [1:0] rst_cnt;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       req_q;
    logic       hold_vld;
    logic [7:0] hold_dat;
    logic       load_fire;

    assign load_fire = (state == S_LOAD) && src_valid;

`ifdef DUT_HOST_TIMEOUT_EN
    logic [11:0] wait_cnt;
    logic        timeout_q;
    logic        wait_expired;

    assign wait_expired = (wait_cnt == 12'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (init) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_REQ)
                wait_cnt <= '0;
            else if (state == S_WAIT && !dut_ack)
                wait_cnt <= wait_cnt + 12'd1;
            if (state == S_IDLE && start)
                timeout_q <= 1'b0;
            else if (state_nxt == S_ERR)
                timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q && !init;
`else
    logic wait_expired;
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (init)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_RST;
            S_RST:     if (rst_cnt == 2'd1) state_nxt = S_LOAD;
            S_LOAD:    if (load_fire && idx == LOAD_LAST) state_nxt = S_REQ;
            S_REQ:     state_nxt = S_WAIT;
            S_WAIT: begin
                if (dut_ack)
                    state_nxt = S_RD_ADDR;
                else if (wait_expired)
                    state_nxt = S_ERR;
            end
            S_RD_ADDR: state_nxt = S_RD_DATA;
            S_RD_DATA: if (res_ready) state_nxt = (idx == RES_LAST) ? S_FIN : S_RD_ADDR;
            S_FIN:     state_nxt = S_IDLE;
            S_ERR:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Load writes are registered so no output depends combinationally on src_valid.
    always_ff @(posedge clk) begin
        if (init) begin
            idx      <= '0;
            rst_cnt  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            req_q    <= 1'b0;
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else begin
            wr_en <= load_fire;
            if (load_fire) begin
                wr_addr <= LOAD_OFS + idx[7:0];
                wr_data <= src_data;
            end
            req_q <= (state == S_REQ);
            case (state)
                S_IDLE: begin
                    idx     <= '0;
                    rst_cnt <= '0;
                end
                S_RST:  rst_cnt <= rst_cnt + 2'd1;
                S_LOAD: begin
                    if (load_fire)
                        idx <= (idx == LOAD_LAST) ? 9'd0 : idx + 9'd1;
                end
                S_RD_DATA: begin
                    if (!hold_vld) begin
                        hold_vld <= 1'b1;
                        hold_dat <= mem_rdata;
                    end
                    if (res_ready) begin
                        hold_vld <= 1'b0;
                        if (idx != RES_LAST)
                            idx <= idx + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // First RD_DATA cycle shows the fresh read; later cycles show the captured copy.
    always_comb begin
        src_ready = 1'b0;
        dut_init  = init;
        dut_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        res_valid = 1'b0;
        res_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!init) begin
            busy      = (state != S_IDLE);
            src_ready = (state == S_LOAD);
            dut_init  = (state == S_RST) || (state == S_ERR);
            dut_req   = req_q;
            done      = (state == S_FIN);
            if (wr_en) begin
                mem_wen   = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end else if (state == S_RD_ADDR || state == S_RD_DATA) begin
                mem_addr = RES_OFS + idx[7:0];
            end
            if (state == S_RD_DATA) begin
                res_valid = 1'b1;
                res_data  = hold_vld ? hold_dat : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dut_host.sv
// Directed bench for dut_host with a memory/core model and write/result scoreboards.
module tb_dut_host;
    localparam int LB = 254;
    localparam int LL = 4;
    localparam int RB = 64;
    localparam int RL = 2;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       init, start, src_valid, src_ready;
    logic [7:0] src_data;
    logic       dut_init, dut_req, dut_ack, mem_wen;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       res_valid, res_ready, busy, done, timeout;
    logic [7:0] res_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] rdata = 8'h00;
    logic [7:0] r0, r1;
    logic       core_ack = 1'b0;
    logic       force_ack;
    logic       ack_enable;
    int         ack_cnt = 0;
    int         bp_low = 0;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    int          req_cnt = 0;
    logic        prev_req = 1'b0;
    logic        hold_pend = 1'b0;
    logic [7:0]  prev_dat = 8'h00;

    always #5 clk = ~clk;

    assign dut_ack   = core_ack | force_ack;
    assign mem_rdata = rdata;

    dut_host #(.LOAD_BASE(LB), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL), .TIMEOUT(TO)) u_dut (
        .clk(clk), .init(init), .start(start),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .dut_init(dut_init), .dut_req(dut_req), .dut_ack(dut_ack),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: registered-read memory with result bytes at RB, ack 10 cycles after req.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        rdata <= (mem_addr == 8'(RB)) ? r0 : (mem_addr == 8'(RB + 1)) ? r1 : mem[mem_addr];
        if (dut_init) begin
            core_ack <= 1'b0;
            ack_cnt  <= 0;
        end else if (dut_req && ack_enable) begin
            ack_cnt <= 10;
        end else if (ack_cnt != 0) begin
            ack_cnt <= ack_cnt - 1;
            if (ack_cnt == 1) core_ack <= 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [15:0] we;
        logic [7:0]  re;
        if (mem_wen) begin
            if (wq.size() == 0) chk("wr_extra", wq.size(), 1);
            else begin
                we = wq.pop_front();
                chk("wr_addr", mem_addr, we[15:8]);
                chk("wr_data", mem_wdata, we[7:0]);
            end
        end
        if (res_valid && hold_pend) chk("res_stable", res_data, prev_dat);
        if (res_valid && res_ready) begin
            if (rq.size() == 0) chk("res_extra", rq.size(), 1);
            else begin
                re = rq.pop_front();
                chk("res_data", res_data, re);
            end
        end
        if (dut_req) begin
            req_cnt++;
            chk("req_after_load", wq.size(), 0);
            chk("req_no_wr", mem_wen, 0);
            chk("req_width", prev_req, 0);
        end
        if (done) chk("done_no_to", timeout, 0);
        hold_pend = res_valid && !res_ready;
        prev_dat  = res_data;
        prev_req  = dut_req;
    end

    initial begin : sink
        int lowc;
        lowc = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (res_valid) begin
                if (lowc >= bp_low) res_ready = 1'b1;
                else begin
                    res_ready = 1'b0;
                    lowc++;
                end
            end else begin
                res_ready = 1'b0;
                lowc = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        src_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        src_valid = 1'b1;
        src_data  = b;
        @(negedge clk);
        while (src_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("src_ready_wait", src_ready, 1);
        @(posedge clk); #1;
        src_valid = 1'b0;
    endtask

    task automatic load_msg(input logic [7:0] seed, input logic [7:0] step, input int gap, input int n);
        logic [7:0] b;
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            b = seed + step * 8'(i);
            a = 8'((LB + i) % 256);
            wq.push_back({a, b});
            send(b, gap);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk(tag, done, 1);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int base;
        int n;
        init = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = 8'h00;
        force_ack = 1'b0; ack_enable = 1'b1; r0 = 8'hA5; r1 = 8'h5A;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dut_init", dut_init, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_req", dut_req, 0);
        @(posedge clk); #1 init = 1'b0;
        @(negedge clk);
        chk("rel_dut_init", dut_init, 0);
        chk("rel_busy", busy, 0);

        // Nominal run, load addresses wrap 254,255,0,1
        rq.push_back(8'hA5); rq.push_back(8'h5A);
        base = req_cnt;
        pulse_start();
        load_msg(8'h11, 8'h11, 0, LL);
        wait_done("nom_done");
        chk("nom_req_once", req_cnt - base, 1);
        chk("nom_res_all", rq.size(), 0);

        // Backpressure both sides, stale ack during RST/LOAD, start pulses during WAIT
        r0 = 8'h3C; r1 = 8'hC3;
        rq.push_back(8'h3C); rq.push_back(8'hC3);
        bp_low = 3;
        force_ack = 1'b1;
        base = req_cnt;
        pulse_start();
        load_msg(8'h80, 8'h07, 1, LL);
        force_ack = 1'b0;
        pulse_start();
        pulse_start();
        chk("bp_still_busy", busy, 1);
        wait_done("bp_done");
        chk("bp_req_once", req_cnt - base, 1);
        chk("bp_res_all", rq.size(), 0);
        bp_low = 0;

        // Reset in the middle of LOAD, then a fresh complete run
        pulse_start();
        load_msg(8'h61, 8'h01, 0, 2);
        @(posedge clk); #1 init = 1'b1;
        @(negedge clk);
        chk("mid_dut_init", dut_init, 1);
        chk("mid_wen", mem_wen, 0);
        chk("mid_busy", busy, 0);
        @(posedge clk); #1 init = 1'b0;
        @(negedge clk);
        chk("mid_idle", busy, 0);
        chk("mid_dut_init_rel", dut_init, 0);
        chk("mid_wr_count", wq.size(), 0);
        r0 = 8'h96; r1 = 8'h69;
        rq.push_back(8'h96); rq.push_back(8'h69);
        base = req_cnt;
        pulse_start();
        load_msg(8'hD0, 8'h03, 0, LL);
        wait_done("rerun_done");
        chk("rerun_req_once", req_cnt - base, 1);

        // Core that never acks
        ack_enable = 1'b0;
        pulse_start();
        load_msg(8'h40, 8'h05, 0, LL);
`ifdef DUT_HOST_TIMEOUT_EN
        n = 0;
        @(negedge clk);
        while (dut_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("to_req_seen", dut_req, 1);
        n = 0;
        while (timeout !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("to_wait_cycles", n, TO);
        chk("to_err_dut_init", dut_init, 1);
        @(negedge clk);
        chk("to_idle", busy, 0);
        chk("to_dut_init_1cyc", dut_init, 0);
        chk("to_sticky", timeout, 1);
        repeat (5) @(negedge clk);
        chk("to_sticky_later", timeout, 1);
        pulse_start();
        @(negedge clk);
        chk("to_cleared", timeout, 0);
        chk("to_rerun_busy", busy, 1);
`else
        repeat (200) @(negedge clk);
        chk("hang_busy", busy, 1);
        chk("hang_no_timeout", timeout, 0);
`endif
        @(posedge clk); #1 init = 1'b1;
        @(posedge clk); #1 init = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        chk("abort_wr_count", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
